dmem_bridge: RTL and testbench

- Sits directly downstream of the MEM stage. Consumes its memory command (memCe/memWr/memRr, address, write data, byte masks).
- Drives a req/ack data-memory bus with variable latency.
- Returns right-justified, optionally sign-extended load data as rdData_i for the MEM stage.
- Holds the pipeline via stall until each access completes, errors, or times out.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_bridge_load_align.sv | 33 +++
 rtl/dmem_bridge.sv | 129 ++++++++++++
 tb/tb_dmem_bridge.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: FSM encoding,
// legal byte-mask patterns and the default bus timeout.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: mask_legal = 1'b1;
      default:                  mask_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_load_align.sv
// Combinational load formatter: right-justifies the lanes selected by r_mask
// and zero- or sign-extends them to 32 bits.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [3:0]  r_mask,
  input  logic        ldSigned,
  output logic [31:0] rd_fmt
);

  logic [1:0]  sh;
  logic [2:0]  pop;
  logic [31:0] val;

  always_comb begin
    sh = 2'd0;
    if (r_mask[0])      sh = 2'd0;
    else if (r_mask[1]) sh = 2'd1;
    else if (r_mask[2]) sh = 2'd2;
    else if (r_mask[3]) sh = 2'd3;

    pop = 3'(r_mask[0]) + 3'(r_mask[1]) + 3'(r_mask[2]) + 3'(r_mask[3]);
    val = bus_rdata >> {sh, 3'b000};

    case (pop)
      3'd1:    rd_fmt = {{24{ldSigned & val[7]}},  val[7:0]};
      3'd2:    rd_fmt = {{16{ldSigned & val[15]}}, val[15:0]};
      default: rd_fmt = val;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to req/ack data-memory bridge: registers the bus command, stalls
// the pipeline until ack, error or timeout, and returns formatted load data.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic        memRr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  input  logic        ldSigned,
  output logic [31:0] rdData,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         act_mask;
  logic               cmd_ok;
  logic               launch;
  logic               ack_hit;
  logic               tmo;
  logic               err_nx;
  logic [31:0]        rd_fmt;
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^memAddr[1:0];

  load_align u_load_align (
    .bus_rdata (bus_rdata),
    .r_mask    (r_mask),
    .ldSigned  (ldSigned),
    .rd_fmt    (rd_fmt)
  );

  always_comb begin
    act_mask = memWr ? w_mask : r_mask;
    cmd_ok   = (memWr ^ memRr) & mask_legal(act_mask);
    state_nx = state;
    launch   = 1'b0;
    ack_hit  = 1'b0;
    tmo      = 1'b0;
    err_nx   = 1'b0;
    stall    = 1'b0;

    case (state)
      IDLE: begin
        stall = memCe;
        if (memCe) begin
          if (cmd_ok) begin
            launch   = 1'b1;
            state_nx = BUSY;
          end else begin
            err_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // ack takes priority over a timeout expiring in the same cycle
        if (bus_ack & bus_req) begin
          ack_hit  = 1'b1;
          state_nx = RESP;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          tmo      = 1'b1;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      rdData    <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      err <= err_nx;
      if (launch) begin
        bus_req   <= 1'b1;
        bus_we    <= memWr;
        bus_addr  <= {memAddr[31:2], 2'b00};
        bus_wdata <= wtData;
        bus_be    <= act_mask;
        cnt       <= '0;
      end else if (state == BUSY) begin
        if (ack_hit) begin
          bus_req <= 1'b0;
          if (!bus_we) rdData <= rd_fmt;
        end else if (tmo) begin
          bus_req <= 1'b0;
          rdData  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// accesses compared against a cycle-count / lane-gather reference model.
module tb_dmem_bridge;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memCe = 1'b0, memWr = 1'b0, memRr = 1'b0, ldSigned = 1'b0;
  logic [31:0] memAddr = '0, wtData = '0;
  logic [3:0]  w_mask = '0, r_mask = '0;
  logic [31:0] rdData;
  logic        stall, err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd = '0;

  logic [3:0] lm [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  logic [3:0] il [9] = '{4'b0000, 4'b0101, 4'b0110, 4'b0111, 4'b1001,
                         4'b1010, 4'b1011, 4'b1101, 4'b1110};

  dmem_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memRr(memRr),
    .memAddr(memAddr), .wtData(wtData), .w_mask(w_mask), .r_mask(r_mask),
    .ldSigned(ldSigned), .rdData(rdData), .stall(stall), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit legal_mask(input logic [3:0] m);
    return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  // Gather enabled lanes low-to-high, then extend from the top gathered bit.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [3:0] m,
                                           input logic sg);
    logic [31:0] v;
    int unsigned n;
    v = '0;
    n = 0;
    for (int unsigned i = 0; i < 4; i++)
      if (m[i]) begin
        v = v | (((rd >> (8 * i)) & 32'hFF) << (8 * n));
        n++;
      end
    if (sg && n > 0 && n < 4 && v[8 * n - 1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Entered and left at a falling edge with the bridge idle.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm, input logic [3:0] rm,
                        input logic sg, input int unsigned delay, input logic [31:0] rdata);
    logic [3:0]  am;
    bit          legal;
    bit          timeout;
    int unsigned busy_n;
    int unsigned stalls;
    am      = we ? wm : rm;
    legal   = (we != re) && legal_mask(am);
    timeout = delay > TMO;
    busy_n  = timeout ? TMO + 1 : delay + 1;
    memCe = 1'b1; memWr = we; memRr = re; memAddr = addr; wtData = wd;
    w_mask = wm; r_mask = rm; ldSigned = sg; bus_ack = 1'b0;
    #1;
    chk("idle_err", err, 0);
    chk("idle_stall", stall, 1);
    stalls = stall;
    @(posedge clk); @(negedge clk);
    if (legal) begin
      for (int unsigned k = 0; k < busy_n; k++) begin
        chk("busy_stall", stall, 1);
        stalls += stall;
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, we);
        chk("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("busy_be", bus_be, am);
        if (we) chk("busy_wdata", bus_wdata, wd);
        bus_ack   = !timeout && k == delay;
        bus_rdata = bus_ack ? rdata : $urandom;
        @(posedge clk); @(negedge clk);
        bus_ack = 1'b0;
      end
      if (timeout)  exp_rd = '0;
      else if (!we) exp_rd = ref_load(rdata, rm, sg);
    end
    chk("resp_stall", stall, 0);
    chk("resp_err", err, (!legal || timeout) ? 1 : 0);
    chk("resp_req", bus_req, 0);
    chk("resp_rd", rdData, exp_rd);
    chk("stall_cycles", stalls, legal ? 1 + busy_n : 1);
    @(posedge clk); @(negedge clk);
    memCe = 1'b0;
    #1;
    chk("post_err", err, 0);
    chk("post_stall", stall, 0);
  endtask

  initial begin
    logic [3:0]  m;
    int unsigned kind;
    logic [31:0] a;

    @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_rd", rdData, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;
    @(negedge clk);

    access(0, 1, 32'h100, 0, 4'b0000, 4'b1111, 0, 0, 32'hDEADBEEF);
    chk("word_load", rdData, 32'hDEADBEEF);
    access(0, 1, 32'h103, 0, 4'b0000, 4'b1000, 1, 4, 32'h80123456);
    chk("sbyte_load", rdData, 32'hFFFFFF80);
    access(0, 1, 32'h103, 0, 4'b0000, 4'b1000, 0, 4, 32'h80123456);
    chk("ubyte_load", rdData, 32'h00000080);
    access(1, 0, 32'h202, 32'hABCD0000, 4'b1100, 4'b0000, 0, 1, 32'h0);
    chk("store_keeps_rd", rdData, 32'h00000080);
    access(1, 1, 32'h300, 0, 4'b1111, 4'b1111, 0, 0, 0);
    access(0, 1, 32'h300, 0, 4'b0000, 4'b0101, 0, 0, 0);
    access(0, 0, 32'h300, 0, 4'b1111, 4'b1111, 0, 0, 0);
    access(0, 1, 32'h400, 0, 4'b0000, 4'b1111, 0, 9, 32'h12345678);
    access(0, 1, 32'h402, 0, 4'b0000, 4'b1100, 1, 4, 32'h9ABC1234);
    chk("ack_at_limit", rdData, 32'hFFFF9ABC);

    // stray ack while idle must be ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_req", bus_req, 0);
    chk("stray_rd", rdData, exp_rd);

    // reset in the middle of an access
    memCe = 1'b1; memWr = 1'b0; memRr = 1'b1; memAddr = 32'h500; r_mask = 4'b1111;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_req", bus_req, 1);
    memCe = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_rd", rdData, 0);
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(0, 1, 32'h504, 0, 4'b0000, 4'b0011, 1, 2, 32'h0000_8001);
    chk("after_rst", rdData, 32'hFFFF8001);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if (kind == 0) begin
        case ($urandom_range(0, 2))
          0:       access(1, 1, a, $urandom, lm[$urandom_range(0, 6)], lm[$urandom_range(0, 6)], 0, 0, 0);
          1:       access(0, 0, a, $urandom, lm[$urandom_range(0, 6)], lm[$urandom_range(0, 6)], 0, 0, 0);
          default: begin
            m = il[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) access(1, 0, a, $urandom, m, 4'b1111, 0, 0, 0);
            else                           access(0, 1, a, 0, 4'b1111, m, 0, 0, 0);
          end
        endcase
      end else if (kind < 5) begin
        access(1, 0, a, $urandom, lm[$urandom_range(0, 6)], 4'b0000, 1'($urandom_range(0, 1)),
               $urandom_range(0, 6), $urandom);
      end else begin
        access(0, 1, a, 0, 4'b0000, lm[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
               $urandom_range(0, 6), $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_ack = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        bus_ack = 1'b0;
        chk("gap_stall", stall, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
